pulse_period_meter: RTL and testbench
=====================================

# pulse_period_meter

Receive-side counterpart of the board's periodic active-low LED strobe. Synchronises an asynchronous active-low pulse train and measures the cycle count between falling edges. Decides lock against an expected period and delivers each measurement over a valid/ready port. Drives the three active-low RGB pins as lock/lost/search indicators, so one board can check another board's heartbeat.

## Interface
- COUNTER_WIDTH, 32, width of period counter and result
- EXPECTED_PERIOD, 10000, nominal strobe period in clk cycles
- TOLERANCE, 16, max allowed |period − EXPECTED_PERIOD| for a match
- TIMEOUT, 20000, cycles without an edge before declaring loss; must exceed EXPECTED_PERIOD + TOLERANCE
- LOCK_COUNT, 3, consecutive matches required to lock
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- strobe_n  in  1  asynchronous active-low pulse input; idles high
- period  out  COUNTER_WIDTH  last measured period (cycles)
- period_valid  out  1  period holds an unconsumed measurement
- period_ready  in  1  consumer accepts period when high with period_valid
- overrun  out  1  one-cycle pulse: unconsumed measurement overwritten
- locked  out  1  high in LOCK state
- timeout  out  1  high in LOST state
- RGB0  out  1  active-low; low while locked
- RGB1  out  1  active-low; low while lost
- RGB2  out  1  active-low; low in MEASURE

## Operation
- Input path: SYNC_STAGES = 2 flops, reset to 1. Edge register reset to 1. `edge` = previous synchronised value 1 and current 0.
- Counter ctr: set to 1 on the edge cycle, otherwise +1 per cycle. Saturates at all-ones; no wrap. Held at 0 in SEARCH and LOST.
- Measurement: on each edge in MEASURE or LOCK, capture period = ctr.
- Match test: |period − EXPECTED_PERIOD| ≤ TOLERANCE, computed in COUNTER_WIDTH+1 bits signed.
- match_cnt: +1 on match, cleared on mismatch, saturates at LOCK_COUNT.
- FSM states: SEARCH, MEASURE, LOCK, LOST (reset: SEARCH).
  - SEARCH: edge → MEASURE. No period captured for the first edge.
  - MEASURE: edge with match_cnt reaching LOCK_COUNT → LOCK. ctr reaching TIMEOUT → LOST.
  - LOCK: mismatching edge → MEASURE with match_cnt = 0. ctr reaching TIMEOUT → LOST.
  - LOST: edge → MEASURE with match_cnt = 0, ctr = 1.
- Output port:
  - Capture sets period_valid. period_valid && period_ready clears it.
  - Capture with period_valid && !period_ready: overwrite and pulse overrun.
  - Capture in the same cycle as an accept: new value loads, period_valid stays 1, no overrun.
- Reset values: period = 0, period_valid = 0, overrun = 0, locked = 0, timeout = 0, RGB0/1/2 = 1.
- Reset asserted mid-operation: all state returns immediately to the reset values. The synchroniser reloads 1, so no spurious edge is seen after release.

## Timing
- strobe_n falling → edge asserted 3 cycles later (2 sync stages + edge register).
- edge → period/period_valid updated 1 cycle later. locked, timeout, RGB* change in the same cycle as the FSM state.
- Period semantics: strobe falling every N cycles yields period = N. Example: strobe every 10000 cycles → 10000.
- Pulses must be low for ≥ 1 cycle and high for ≥ 2 cycles between them. Shorter pulses may be missed; there is no glitch filter.
- Timeout fires on the cycle ctr == TIMEOUT. At most one state transition per cycle; edge takes priority over timeout in the same cycle.

## Structure
- Package pulse_meter_pkg holds the state enum (SEARCH, MEASURE, LOCK, LOST) and the default LOCK_COUNT constant.
- Sub-module sync_falling_edge contains the synchroniser and falling-edge detector (clk, rst, async_n in, edge out).
- The top level contains the counter, FSM, match logic and output register.

## Test plan
Use EXPECTED_PERIOD=100, TOLERANCE=4, TIMEOUT=250.
- Reset then 4 strobes every 100 cycles, period_ready=1 → period=100 three times, locked=1 and RGB0=0 on the third capture.
- Locked, one period of 110 → period=110, locked=0, state MEASURE, RGB2=0. Three more periods of 100 → relock.
- Locked, strobe stops → timeout=1 and RGB1=0 exactly 250 cycles after the last ctr reset. Next edge → MEASURE, no period capture.
- period_ready=0 across two captures (100, 102) → overrun pulses once, period=102, period_valid stays 1. ready=1 → valid clears the next cycle.
- Capture coincides with accept → new value held, period_valid=1, overrun=0.
- rst low mid-count in LOCK → all outputs at reset values within the same cycle. After release, no capture before two fresh edges.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse period meter.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCK    = 2'd2,
        LOST    = 2'd3
    } meter_state_t;

    localparam int unsigned DEFAULT_LOCK_COUNT = 3;

endpackage

// File: rtl/sync_falling_edge.sv
// Two-flop synchroniser for an async active-low input plus a registered
// falling-edge detector; pin fall to edge_pulse is three clocks.
module sync_falling_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_n,
    output logic edge_pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Resetting to 1 (the idle level) avoids a spurious edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], async_n};
            prev_q     <= sync_q[1];
            edge_pulse <= prev_q & ~sync_q[1];
        end
    end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the period of an async active-low strobe, tracks lock against
// an expected period and reports each measurement on a valid/ready port.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH   = 32,
    parameter int unsigned EXPECTED_PERIOD = 10000,
    parameter int unsigned TOLERANCE       = 16,
    parameter int unsigned TIMEOUT         = 20000,
    parameter int unsigned LOCK_COUNT      = DEFAULT_LOCK_COUNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     strobe_n,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic                     period_valid,
    input  logic                     period_ready,
    output logic                     overrun,
    output logic                     locked,
    output logic                     timeout,
    output logic                     RGB0,
    output logic                     RGB1,
    output logic                     RGB2
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [COUNTER_WIDTH-1:0] EXP_C = COUNTER_WIDTH'(EXPECTED_PERIOD);
    localparam logic [COUNTER_WIDTH-1:0] TOL_C = COUNTER_WIDTH'(TOLERANCE);
    localparam logic [COUNTER_WIDTH-1:0] TMO_C = COUNTER_WIDTH'(TIMEOUT);
    localparam logic [MW-1:0]            LCK_C = MW'(LOCK_COUNT);

    meter_state_t             state, state_nxt;
    logic [COUNTER_WIDTH-1:0] ctr, ctr_nxt;
    logic [MW-1:0]            match_cnt, match_cnt_nxt;
    logic                     edge_pulse;
    logic                     capture;
    logic                     is_match;

    // |p - EXPECTED| <= TOLERANCE, evaluated one bit wider and signed.
    function automatic logic period_match(input logic [COUNTER_WIDTH-1:0] p);
        logic signed [COUNTER_WIDTH:0] diff;
        diff = $signed({1'b0, p}) - $signed({1'b0, EXP_C});
        if (diff < 0) diff = -diff;
        return diff <= $signed({1'b0, TOL_C});
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNTER_WIDTH-1:0] ctr_inc(input logic [COUNTER_WIDTH-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    sync_falling_edge u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_n    (strobe_n),
        .edge_pulse (edge_pulse)
    );

    assign capture  = edge_pulse && (state == MEASURE || state == LOCK);
    assign is_match = period_match(ctr);

    // Next state, lock qualification and period counter; edge beats timeout.
    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        case (state)
            SEARCH: begin
                if (edge_pulse) begin
                    state_nxt     = MEASURE;
                    match_cnt_nxt = '0;
                end
            end
            MEASURE: begin
                if (edge_pulse) begin
                    if (is_match) begin
                        match_cnt_nxt = (match_cnt == LCK_C) ? match_cnt : match_cnt + 1'b1;
                        if (match_cnt_nxt == LCK_C) state_nxt = LOCK;
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end else if (ctr >= TMO_C) begin
                    state_nxt = LOST;
                end
            end
            LOCK: begin
                if (edge_pulse) begin
                    if (!is_match) begin
                        state_nxt     = MEASURE;
                        match_cnt_nxt = '0;
                    end
                end else if (ctr >= TMO_C) begin
                    state_nxt = LOST;
                end
            end
            LOST: begin
                if (edge_pulse) begin
                    state_nxt     = MEASURE;
                    match_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt     = SEARCH;
                match_cnt_nxt = '0;
            end
        endcase

        if (edge_pulse)
            ctr_nxt = COUNTER_WIDTH'(1);
        else if (state_nxt == SEARCH || state_nxt == LOST)
            ctr_nxt = '0;
        else
            ctr_nxt = ctr_inc(ctr);
    end

    // State, counter and match history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            ctr       <= '0;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ctr       <= ctr_nxt;
            match_cnt <= match_cnt_nxt;
        end
    end

    // Output port: a capture always wins; overrun flags a lost measurement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= capture && period_valid && !period_ready;
            if (capture) begin
                period       <= ctr;
                period_valid <= 1'b1;
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
        end
    end

    assign locked  = (state == LOCK);
    assign timeout = (state == LOST);
    assign RGB0    = !(state == LOCK);
    assign RGB1    = !(state == LOST);
    assign RGB2    = !(state == MEASURE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with a small test configuration.
module tb_pulse_period_meter;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          strobe_n;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          period_ready;
    logic          overrun;
    logic          locked;
    logic          timeout;
    logic          RGB0, RGB1, RGB2;

    int cyc       = 0;
    int ovr_cnt   = 0;
    int last_fall = 0;
    int have_last = 0;
    int checks    = 0;
    int errors    = 0;

    // st: 0 SEARCH, 1 MEASURE, 2 LOCK, 3 LOST
    typedef struct {
        int gap;
        int ready;
        int exp_period;
        int exp_valid;
        int exp_st;
        int exp_ovr;
    } vec_t;

    vec_t vecs [17];

    pulse_period_meter #(
        .COUNTER_WIDTH   (CW),
        .EXPECTED_PERIOD (100),
        .TOLERANCE       (4),
        .TIMEOUT         (250),
        .LOCK_COUNT      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .strobe_n     (strobe_n),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun),
        .locked       (locked),
        .timeout      (timeout),
        .RGB0         (RGB0),
        .RGB1         (RGB1),
        .RGB2         (RGB2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_state(input string name, input int st);
        chk({name, ".locked"},  int'(locked),  int'(st == 2));
        chk({name, ".timeout"}, int'(timeout), int'(st == 3));
        chk({name, ".RGB0"},    int'(RGB0),    int'(st != 2));
        chk({name, ".RGB1"},    int'(RGB1),    int'(st != 3));
        chk({name, ".RGB2"},    int'(RGB2),    int'(st != 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Falling strobe 'gap' cycles after the previous one, low for one cycle.
    task automatic fall_at(input int gap);
        if (have_last != 0) wait_until(last_fall + gap);
        strobe_n  = 1'b0;
        last_fall = cyc;
        have_last = 1;
        tick();
        strobe_n = 1'b1;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int ovr0;
        ovr0 = ovr_cnt;
        period_ready = (v.ready != 0);
        fall_at(v.gap);
        wait_until(last_fall + 5);
        chk({name, ".period"}, int'(period), v.exp_period);
        chk({name, ".valid"},  int'(period_valid), v.exp_valid);
        chk({name, ".overrun_count"}, ovr_cnt - ovr0, v.exp_ovr);
        chk_state(name, v.exp_st);
    endtask

    initial begin
        vecs[0]  = '{0,   1, 0,   0, 1, 0};
        vecs[1]  = '{100, 1, 100, 0, 1, 0};
        vecs[2]  = '{100, 1, 100, 0, 1, 0};
        vecs[3]  = '{100, 1, 100, 0, 2, 0};
        vecs[4]  = '{110, 1, 110, 0, 1, 0};
        vecs[5]  = '{100, 1, 100, 0, 1, 0};
        vecs[6]  = '{100, 1, 100, 0, 1, 0};
        vecs[7]  = '{100, 1, 100, 0, 2, 0};
        vecs[8]  = '{104, 1, 104, 0, 2, 0};
        vecs[9]  = '{96,  1, 96,  0, 2, 0};
        vecs[10] = '{95,  1, 95,  0, 1, 0};
        vecs[11] = '{105, 1, 105, 0, 1, 0};
        vecs[12] = '{100, 1, 100, 0, 1, 0};
        vecs[13] = '{100, 1, 100, 0, 1, 0};
        vecs[14] = '{100, 1, 100, 0, 2, 0};
        vecs[15] = '{100, 0, 100, 1, 2, 0};
        vecs[16] = '{102, 0, 102, 1, 2, 1};

        rst          = 1'b0;
        strobe_n     = 1'b1;
        period_ready = 1'b1;
        tick();
        tick();
        chk("reset.period", int'(period), 0);
        chk("reset.valid", int'(period_valid), 0);
        chk("reset.overrun", int'(overrun), 0);
        chk_state("reset", 0);
        #3 rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk_state("idle_search", 0);

        for (int i = 0; i < 17; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Accept after two unconsumed captures: valid drops the next cycle.
        chk("accept.valid_before", int'(period_valid), 1);
        period_ready = 1'b1;
        tick();
        chk("accept.valid_after", int'(period_valid), 0);

        // Capture in the same cycle as an accept.
        run_vec("coin_pre", '{100, 0, 100, 1, 2, 0});
        fall_at(101);
        wait_until(last_fall + 3);
        period_ready = 1'b1;
        tick();
        chk("coin.period", int'(period), 101);
        chk("coin.valid", int'(period_valid), 1);
        chk("coin.overrun", int'(overrun), 0);
        period_ready = 1'b0;
        tick();
        chk("coin.valid_hold", int'(period_valid), 1);
        chk("coin.overrun_after", int'(overrun), 0);
        chk_state("coin", 2);

        // Strobe stops while locked: LOST exactly when ctr reaches 250.
        period_ready = 1'b1;
        wait_until(last_fall + 253);
        chk("tmo.before", int'(timeout), 0);
        chk("tmo.locked_before", int'(locked), 1);
        tick();
        chk_state("tmo.after", 3);
        run_vec("lost_edge", '{300, 1, 101, 0, 1, 0});
        run_vec("relock1",   '{100, 1, 100, 0, 1, 0});
        run_vec("relock2",   '{100, 1, 100, 0, 1, 0});
        run_vec("relock3",   '{100, 1, 100, 0, 2, 0});

        // Asynchronous reset mid-count while locked.
        wait_until(last_fall + 40);
        #2 rst = 1'b0;
        #1;
        chk("arst.period", int'(period), 0);
        chk("arst.valid", int'(period_valid), 0);
        chk("arst.overrun", int'(overrun), 0);
        chk_state("arst", 0);
        tick();
        tick();
        #3 rst = 1'b1;
        have_last = 0;
        for (int i = 0; i < 20; i++) tick();
        chk_state("post_rst_idle", 0);
        chk("post_rst.valid", int'(period_valid), 0);
        run_vec("post_rst_e1", '{0,   1, 0,   0, 1, 0});
        run_vec("post_rst_e2", '{100, 0, 100, 1, 1, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
